// File: rtl/cheshire_uart_mon.sv
// Multi-channel UART receive monitor: per-channel 2-flop sync, frame decoder and
// elastic FIFO draining into a valid/ready stream, with framing/parity/break/overflow reporting.
module cheshire_uart_mon #(
    parameter int unsigned NumChan   = 1,
    parameter int unsigned DataBits  = 8,
    parameter int unsigned FifoDepth = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [15:0]                  div_i,
    input  logic [1:0]                   parity_i,
    input  logic                         stop2_i,
    input  logic [NumChan-1:0]           uart_rx_i,
    output logic [NumChan-1:0]           valid_o,
    input  logic [NumChan-1:0]           ready_i,
    output logic [NumChan*DataBits-1:0]  data_o,
    output logic [NumChan-1:0]           perr_o,
    output logic [NumChan-1:0]           ferr_o,
    output logic [NumChan-1:0]           brk_o,
    output logic [NumChan*16-1:0]        drop_cnt_o
);
    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned BitW = $clog2(DataBits);
    localparam logic [PtrW:0] FullCnt = (PtrW+1)'(FifoDepth);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

    logic [15:0] div_clamped;
    assign div_clamped = (div_i < 16'd4) ? 16'd4 : div_i;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        logic                sync1_q, sync2_q;
        state_e              state_q;
        logic [15:0]         div_q, cnt_q;
        logic [1:0]          par_q;
        logic                stop2_q, stop_idx_q, stop_low_q, brk_wait_q;
        logic                perr_q, ferr_q, brk_q;
        logic [BitW-1:0]     bit_q;
        logic [DataBits-1:0] shift_q;
        logic                sample, last_stop, any_low, push, pop, full, empty, accept;
        logic [DataBits:0]   mem_q [FifoDepth];
        logic [PtrW-1:0]     wr_q, rd_q;
        logic [PtrW:0]       count_q;
        logic [15:0]         drop_q;

        assign sample    = (cnt_q == 16'd0);
        assign last_stop = !stop2_q || stop_idx_q;
        assign any_low   = stop_low_q || !sync2_q;
        assign push      = (state_q == STOP) && !brk_wait_q && sample && last_stop && !any_low;
        assign empty     = (count_q == '0);
        assign full      = (count_q == FullCnt);
        assign pop       = !empty && ready_i[c];
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        assign accept    = push && (!full || pop);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync1_q    <= 1'b1;
                sync2_q    <= 1'b1;
                state_q    <= IDLE;
                ferr_q     <= 1'b0;
                brk_q      <= 1'b0;
                brk_wait_q <= 1'b0;
            end else begin
                sync1_q <= uart_rx_i[c];
                sync2_q <= sync1_q;
                ferr_q  <= 1'b0;
                brk_q   <= 1'b0;
                if (state_q != IDLE && !sample) cnt_q <= cnt_q - 16'd1;
                case (state_q)
                    IDLE: if (!sync2_q) begin
                        div_q   <= div_clamped;
                        par_q   <= parity_i;
                        stop2_q <= stop2_i;
                        cnt_q   <= div_clamped >> 1;
                        state_q <= START;
                    end
                    START: if (sample) begin
                        cnt_q   <= div_q - 16'd1;
                        bit_q   <= '0;
                        state_q <= sync2_q ? IDLE : DATA;
                    end
                    DATA: if (sample) begin
                        cnt_q   <= div_q - 16'd1;
                        shift_q <= {sync2_q, shift_q[DataBits-1:1]};
                        bit_q   <= bit_q + BitW'(1);
                        if (bit_q == BitW'(DataBits - 1)) begin
                            perr_q     <= 1'b0;
                            stop_idx_q <= 1'b0;
                            stop_low_q <= 1'b0;
                            state_q    <= (par_q == 2'd1 || par_q == 2'd2) ? PAR : STOP;
                        end
                    end
                    PAR: if (sample) begin
                        cnt_q   <= div_q - 16'd1;
                        perr_q  <= (^shift_q) ^ sync2_q ^ (par_q == 2'd2);
                        state_q <= STOP;
                    end
                    STOP: begin
                        if (brk_wait_q) begin
                            // Break holds here until the line is seen idle again.
                            if (sync2_q) begin
                                brk_wait_q <= 1'b0;
                                state_q    <= IDLE;
                            end
                        end else if (sample) begin
                            cnt_q <= div_q - 16'd1;
                            if (!last_stop) begin
                                stop_idx_q <= 1'b1;
                                stop_low_q <= any_low;
                            end else if (any_low && shift_q == '0) begin
                                brk_q      <= 1'b1;
                                brk_wait_q <= 1'b1;
                            end else begin
                                ferr_q  <= any_low;
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wr_q    <= '0;
                rd_q    <= '0;
                count_q <= '0;
                drop_q  <= '0;
            end else begin
                if (accept) wr_q <= wr_q + PtrW'(1);
                if (pop)    rd_q <= rd_q + PtrW'(1);
                if (accept && !pop)      count_q <= count_q + (PtrW+1)'(1);
                else if (!accept && pop) count_q <= count_q - (PtrW+1)'(1);
                if (push && !accept && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (accept) mem_q[wr_q] <= {perr_q, shift_q};
        end

        assign valid_o[c]                      = !empty;
        assign data_o[c*DataBits +: DataBits]  = empty ? '0 : mem_q[rd_q][DataBits-1:0];
        assign perr_o[c]                       = !empty && mem_q[rd_q][DataBits];
        assign ferr_o[c]                       = ferr_q;
        assign brk_o[c]                        = brk_q;
        assign drop_cnt_o[c*16 +: 16]          = drop_q;
    end

endmodule

// File: tb/tb_cheshire_uart_mon.sv
// Bench for cheshire_uart_mon: directed UART frames on four channels, a queue-based
// expected-entry model checked on every pop, and literal checks on key results.
module tb_cheshire_uart_mon;
    localparam int NC = 4;
    localparam int DB = 8;
    localparam int FD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      div;
    logic [1:0]       parity;
    logic             stop2;
    logic [NC-1:0]    rx;
    logic [NC-1:0]    ready;
    logic [NC-1:0]    valid_o, perr_o, ferr_o, brk_o;
    logic [NC*DB-1:0] data_o;
    logic [NC*16-1:0] drop_cnt_o;

    always #5 clk = ~clk;

    cheshire_uart_mon #(.NumChan(NC), .DataBits(DB), .FifoDepth(FD)) dut (
        .clk_i(clk), .rst_i(rst), .div_i(div), .parity_i(parity), .stop2_i(stop2),
        .uart_rx_i(rx), .valid_o(valid_o), .ready_i(ready), .data_o(data_o),
        .perr_o(perr_o), .ferr_o(ferr_o), .brk_o(brk_o), .drop_cnt_o(drop_cnt_o)
    );

    typedef struct packed {
        logic [1:0] ch;
        logic [8:0] ent;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   ferr_seen[NC], brk_seen[NC], ferr_exp[NC], brk_exp[NC], drop_exp[NC];
    int   cmp_idx;
    int   n_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int pending(input int ch);
        int n = 0;
        foreach (expq[k]) if (int'(expq[k].ch) == ch) n++;
        return n;
    endfunction

    // Model-driven compare: every pop must match the oldest expected entry of that channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NC; c++) begin
                if (ferr_o[c]) ferr_seen[c]++;
                if (brk_o[c]) brk_seen[c]++;
                if (valid_o[c] && ready[c]) begin
                    cmp_idx = -1;
                    for (int k = 0; k < expq.size(); k++)
                        if (cmp_idx < 0 && int'(expq[k].ch) == c) cmp_idx = k;
                    if (cmp_idx < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_ch%0d actual=%0h expected=none", c,
                                 {perr_o[c], data_o[c*DB +: DB]});
                    end else begin
                        chk($sformatf("pop_ch%0d", c), 64'({perr_o[c], data_o[c*DB +: DB]}),
                            64'(expq[cmp_idx].ent));
                        expq.delete(cmp_idx);
                    end
                end
            end
        end
    end

    task automatic send_bits(input int ch, input int per, input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx[ch] = bits[i];
            repeat (per) @(posedge clk);
            #1;
        end
        rx[ch] = 1'b1;
    endtask

    // Builds the frame and records what the monitor must report for it.
    task automatic send_frame(input int ch, input int per, input logic [7:0] d, input int pmode,
                              input logic pbit, input logic [1:0] stops, input int nstop);
        logic [31:0] bits;
        int          n;
        logic        p;
        logic        all_hi;
        exp_t        e;
        bits    = '0;
        bits[8:1] = d;
        n       = 9;
        if (pmode == 1 || pmode == 2) begin
            bits[n] = pbit;
            n++;
        end
        all_hi = 1'b1;
        for (int s = 0; s < nstop; s++) begin
            bits[n] = stops[s];
            all_hi  = all_hi & stops[s];
            n++;
        end
        if (all_hi) begin
            p = (pmode == 1) ? ((^d) ^ pbit) : (pmode == 2) ? ~((^d) ^ pbit) : 1'b0;
            if (!ready[ch] && pending(ch) >= FD) drop_exp[ch]++;
            else begin
                e.ch  = 2'(ch);
                e.ent = {p, d};
                expq.push_back(e);
            end
        end else if (d == 8'h00) brk_exp[ch]++;
        else ferr_exp[ch]++;
        send_bits(ch, per, bits, n);
    endtask

    task automatic wait_head(input int ch, input logic [7:0] d, input logic p, input string name);
        int n = 0;
        while (!valid_o[ch] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, 64'(valid_o[ch]), 64'd1);
        if (valid_o[ch]) begin
            chk({name, "_data"}, 64'(data_o[ch*DB +: DB]), 64'(d));
            chk({name, "_perr"}, 64'(perr_o[ch]), 64'(p));
        end
    endtask

    task automatic frame_expect(input int ch, input int per, input logic [7:0] d, input int pmode,
                                input logic pbit, input logic [1:0] stops, input int nstop,
                                input logic exp_p, input string name);
        fork
            send_frame(ch, per, d, pmode, pbit, stops, nstop);
            wait_head(ch, d, exp_p, name);
        join
        repeat (30) @(posedge clk);
        #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; div = 16'd16; parity = 2'd0; stop2 = 1'b0; rx = '1; ready = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_perr", 64'(perr_o), 64'd0);
        chk("rst_ferr", 64'(ferr_o), 64'd0);
        chk("rst_brk", 64'(brk_o), 64'd0);
        chk("rst_drop", drop_cnt_o, 64'd0);
        @(posedge clk);
        #1;

        // 8N1 0xA5: entry appears one cycle after the stop sample.
        fork
            send_frame(0, 16, 8'hA5, 0, 1'b0, 2'b11, 1);
            begin
                n_cyc = 0;
                while (!valid_o[0] && n_cyc < 400) begin
                    @(negedge clk);
                    n_cyc++;
                end
                chk("a5_latency_window", 64'(n_cyc >= 150 && n_cyc <= 165), 64'd1);
                chk("a5_data", 64'(data_o[7:0]), 64'hA5);
                chk("a5_perr", 64'(perr_o[0]), 64'd0);
            end
        join
        repeat (30) @(posedge clk);
        #1;

        parity = 2'd1;
        frame_expect(0, 16, 8'h03, 1, 1'b1, 2'b11, 1, 1'b1, "even_p1");
        frame_expect(0, 16, 8'h03, 1, 1'b0, 2'b11, 1, 1'b0, "even_p0");
        parity = 2'd2;
        frame_expect(0, 16, 8'h03, 2, 1'b1, 2'b11, 1, 1'b0, "odd_p1");
        frame_expect(0, 16, 8'h03, 2, 1'b0, 2'b11, 1, 1'b1, "odd_p0");
        parity = 2'd0;

        send_frame(0, 16, 8'h5A, 0, 1'b0, 2'b00, 1);
        repeat (40) @(posedge clk);
        #1;
        chk("ferr_once", 64'(ferr_seen[0]), 64'd1);
        chk("ferr_model", 64'(ferr_seen[0]), 64'(ferr_exp[0]));

        stop2 = 1'b1;
        send_frame(0, 16, 8'h5A, 0, 1'b0, 2'b01, 2);
        repeat (40) @(posedge clk);
        #1;
        chk("ferr_stop2", 64'(ferr_seen[0]), 64'd2);
        frame_expect(0, 16, 8'h66, 0, 1'b0, 2'b11, 2, 1'b0, "stop2_ok");
        stop2 = 1'b0;

        brk_exp[0]++;
        send_bits(0, 16, 32'h0, 20);
        repeat (40) @(posedge clk);
        #1;
        chk("brk_once", 64'(brk_seen[0]), 64'd1);
        chk("brk_no_ferr", 64'(ferr_seen[0]), 64'd2);

        // Short low glitch must be rejected at the start-bit check.
        rx[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1 rx[0] = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("glitch_valid", 64'(valid_o[0]), 64'd0);
        chk("glitch_ferr", 64'(ferr_seen[0]), 64'd2);
        chk("glitch_brk", 64'(brk_seen[0]), 64'd1);

        ready[0] = 1'b0;
        for (int i = 0; i < 6; i++) send_frame(0, 16, 8'(8'h10 + i), 0, 1'b0, 2'b11, 1);
        repeat (40) @(posedge clk);
        #1;
        chk("fifo_drop", drop_cnt_o[15:0], 64'd2);
        chk("fifo_drop_model", drop_cnt_o[15:0], 64'(drop_exp[0]));
        chk("fifo_head_valid", 64'(valid_o[0]), 64'd1);
        chk("fifo_head_data", 64'(data_o[7:0]), 64'h10);
        ready[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("fifo_drained", 64'(pending(0)), 64'd0);
        chk("fifo_empty", 64'(valid_o[0]), 64'd0);

        // Divisor is captured per channel at start detection; ch3 uses a clamped divisor.
        fork
            begin
                div = 16'd16;
                frame_expect(0, 16, 8'h5C, 0, 1'b0, 2'b11, 1, 1'b0, "mc0");
            end
            begin
                repeat (6) @(posedge clk);
                #1 div = 16'd17;
                frame_expect(1, 17, 8'hC3, 0, 1'b0, 2'b11, 1, 1'b0, "mc1");
            end
            begin
                repeat (12) @(posedge clk);
                #1 div = 16'd100;
                frame_expect(2, 100, 8'h96, 0, 1'b0, 2'b11, 1, 1'b0, "mc2");
            end
            begin
                repeat (18) @(posedge clk);
                #1 div = 16'd1;
                frame_expect(3, 4, 8'h3A, 0, 1'b0, 2'b11, 1, 1'b0, "mc3");
            end
        join
        div = 16'd16;
        repeat (20) @(posedge clk);
        #1;

        fork
            send_bits(0, 16, 32'h3FE, 10);
            begin
                repeat (48) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                for (int c = 0; c < NC; c++) drop_exp[c] = 0;
                @(negedge clk);
                chk("mid_rst_valid", 64'(valid_o), 64'd0);
                chk("mid_rst_data", 64'(data_o), 64'd0);
                chk("mid_rst_perr", 64'(perr_o), 64'd0);
                chk("mid_rst_ferr", 64'(ferr_o), 64'd0);
                chk("mid_rst_brk", 64'(brk_o), 64'd0);
                chk("mid_rst_drop", drop_cnt_o, 64'd0);
            end
        join
        repeat (40) @(posedge clk);
        #1;
        frame_expect(0, 16, 8'h3C, 0, 1'b0, 2'b11, 1, 1'b0, "post_rst");

        chk("all_popped", 64'(expq.size()), 64'd0);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("ferr_total_ch%0d", c), 64'(ferr_seen[c]), 64'(ferr_exp[c]));
            chk($sformatf("brk_total_ch%0d", c), 64'(brk_seen[c]), 64'(brk_exp[c]));
            chk($sformatf("drop_total_ch%0d", c), drop_cnt_o[c*16 +: 16], 64'(drop_exp[c]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
